pin_combine_pipe: RTL
=====================

// Module: pin_combine_pipe
// PURPOSE
//  Multi-channel, parametrised successor of the two-input combiner test cell:
//  CHANNELS lanes of WIDTH-bit operands, run-time selectable op, tie-off constant
//  for disabled lanes. Registered valid/ready pipeline with a 2-entry skid buffer,
//  so full throughput is kept under downstream backpressure.
//  Sits between the test-pattern source and the port-order checkers.
// PARAMETERS
//  WIDTH     8      bits per channel operand/result
//  CHANNELS  4      number of independent lanes (>=1)
//  DEF_CONST 32'h1  tie-off value; lower WIDTH bits drive every disabled lane
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               reset: asynchronous, active-high
//  in_valid   in   1               input beat valid
//  in_ready   out  1               block can accept a beat
//  in_a       in   CHANNELS*WIDTH  operand A, lane k = [k*WIDTH +: WIDTH]
//  in_b       in   CHANNELS*WIDTH  operand B, same packing
//  mode       in   2               00 AND, 01 OR, 10 XOR, 11 pass A
//  chan_en    in   CHANNELS        per-lane enable; 0 -> lane forced to tie-off
//  out_valid  out  1               output beat valid
//  out_ready  in   1               downstream accepts the beat
//  out_data   out  CHANNELS*WIDTH  combined result
//  out_count  out  16              completed output handshakes, wraps
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_count=0,
//    skid empty, in_ready=0; in_ready=1 from the first clk edge after release.
//  - Accept = in_valid & in_ready. mode, chan_en, in_a, in_b are sampled together
//    on accept; later changes do not affect beats already in flight.
//  - Per lane: result = chan_en[k] ? op(a_k,b_k) : DEF_CONST[WIDTH-1:0].
//    Bitwise, no carries; result width = WIDTH.
//  - Latency: 1 clk from accept to out_valid when the output register is free.
//  - Storage: output register O, skid register S. States EMPTY, ONE (O full),
//    TWO (O and S full).
//    EMPTY: accept -> ONE.
//    ONE: accept & out_ready -> ONE (new beat into O);
//         accept & ~out_ready -> TWO (beat into S);
//         ~accept & out_ready -> EMPTY.
//    TWO: in_ready=0; out_ready -> S moves to O -> ONE, and in_ready=1 next clk.
//  - in_ready is registered, = (state != TWO). No combinational in->out path.
//    Beat order is always preserved.
//  - While out_valid & ~out_ready, out_data holds stable. out_valid never drops
//    without a handshake.
//  - out_count +1 on every out_valid & out_ready; 16'hFFFF wraps to 0.
//  - Reset mid-operation: all buffered beats are discarded, with no partial output.
//  - X on in_a/in_b of a disabled lane must not reach out_data.
// TESTING
//  1 Reset release, in_valid=0 -> in_ready 0 then 1 next clk; out_valid=0, out_count=0.
//  2 WIDTH=8, CHANNELS=4, mode=00, a=32'hF0F0_FF00, b=32'hFF00_0FF0, chan_en=4'hF,
//    out_ready=1 -> out_data=32'hF000_0F00 one clk later; out_count=1.
//  3 mode=10, chan_en=4'b0101, a=32'hAAAA_AAAA, b=32'h5555_5555
//    -> out_data=32'h01FF_01FF (lanes 1 and 3 = DEF_CONST[7:0]=8'h01).
//  4 Stream beats 1,2,3 back-to-back; out_ready low for 3 clks after beat 1 is output
//    -> in_ready drops after the 2nd accept, out_data holds beat 1; on out_ready=1
//    beats emerge 1,2,3 in order with no loss or duplication.
//  5 Preload out_count to 16'hFFFE via 2 less than 65536 transfers (or force),
//    then 2 handshakes -> out_count = 16'hFFFF, then 16'h0000.
//  6 Assert rst while in state TWO -> out_valid=0 immediately (async), out_count=0;
//    after release the first output is the next accepted beat only.

Source files
------------

// File: rtl/pin_combine_if.sv
// Handshake bundle for pin_combine_pipe: input beat channel, output beat channel and
// the completed-transfer counter.
interface pin_combine_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_a;
  logic [CHANNELS*WIDTH-1:0] in_b;
  logic [1:0]                mode;
  logic [CHANNELS-1:0]       chan_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [15:0]               out_count;

  modport master (
    output in_valid, in_a, in_b, mode, chan_en, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, chan_en, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/pin_combine_pipe.sv
// Per-lane bitwise combiner (AND/OR/XOR/pass-A, tie-off for disabled lanes) behind a
// registered valid/ready stage with a one-beat skid register.
module pin_combine_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter logic [31:0] DEF_CONST = 32'h1
) (
  input logic          clk,
  input logic          rst,
  pin_combine_if.slave bus
);

  localparam int unsigned     DW     = WIDTH * CHANNELS;
  localparam logic [WIDTH-1:0] TieOff = DEF_CONST[WIDTH-1:0];

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   o_q, o_d;
  logic [DW-1:0]   s_q, s_d;
  logic [DW-1:0]   comb;
  logic [WIDTH-1:0] lane_a, lane_b, lane_r;
  logic            in_ready_q;
  logic [15:0]     count_q;
  logic            accept;
  logic            pop;

  // Disabled lanes select the constant, so whatever sits on their operands is never used.
  always_comb begin
    comb   = '0;
    lane_a = '0;
    lane_b = '0;
    lane_r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      lane_a = bus.in_a[k*WIDTH +: WIDTH];
      lane_b = bus.in_b[k*WIDTH +: WIDTH];
      case (bus.mode)
        2'b00:   lane_r = lane_a & lane_b;
        2'b01:   lane_r = lane_a | lane_b;
        2'b10:   lane_r = lane_a ^ lane_b;
        default: lane_r = lane_a;
      endcase
      comb[k*WIDTH +: WIDTH] = bus.chan_en[k] ? lane_r : TieOff;
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = (state_q != StEmpty) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          o_d     = comb;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && bus.out_ready) begin
          o_d = comb;
        end else if (accept) begin
          s_d     = comb;
          state_d = StTwo;
        end else if (bus.out_ready) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (bus.out_ready) begin
          o_d     = s_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      o_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != StTwo);
      if (pop) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = o_q;
  assign bus.out_count = count_q;

endmodule
